// File: rtl/rr_var_picker.sv
// Round-robin variable picker for the solver's branching logic.
//
// Given a mask of unassigned variables, returns the index of the first
// unassigned variable at or after an internal pointer, wrapping around.
// The sampled mask is realigned (rotated right by the pointer) into rot_q,
// then priority-encoded. After each non-empty pick that is accepted, the
// pointer moves to one past the granted index. An empty pick leaves the
// pointer unchanged.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous, active-high reset
//   req_valid    mask presented for a pick
//   req_ready    block can accept a request (IDLE only)
//   mask         bit i = 1: variable i unassigned; sampled on request handshake
//   grant_valid  pick result available (HOLD)
//   grant_ready  consumer accepts result
//   grant_idx    picked variable index, 0..N-1
//   grant_none   sampled mask was all zero; grant_idx = 0
module rr_var_picker #(
   parameter int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] mask,
   output logic         grant_valid,
   input  logic         grant_ready,
   output logic [W-1:0] grant_idx,
   output logic         grant_none
);

   localparam logic [W:0]   NWide   = (W+1)'(N);
   localparam logic [W-1:0] LastIdx = W'(N - 1);

   typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   ptr_q, ptr_d;
   logic [N-1:0]   rot_q, rot_d;
   logic [W-1:0]   grant_idx_q, grant_idx_d;
   logic           grant_none_q, grant_none_d;

   // Rotate right by ptr: doubling the mask makes the wrap work for any N,
   // not just powers of two. ptr is always < N so the low N bits suffice.
   logic [2*N-1:0] mask_dbl_shr;
   logic [N-1:0]   mask_rot;

   assign mask_dbl_shr = {mask, mask} >> ptr_q;
   assign mask_rot     = mask_dbl_shr[N-1:0];

   // Lowest set bit of the realigned mask = distance from ptr to the pick.
   logic [W-1:0] lowest;

   always_comb begin
      lowest = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot_q[i]) begin
            lowest = W'(i);
         end
      end
   end

   // ptr + offset computed one bit wider, then folded back into 0..N-1.
   logic [W:0]   idx_sum;
   logic [W-1:0] idx_wrapped;

   always_comb begin
      idx_sum     = {1'b0, ptr_q} + {1'b0, lowest};
      idx_wrapped = idx_sum[W-1:0];
      if (idx_sum >= NWide) begin
         idx_wrapped = W'(idx_sum - NWide);
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rot_d        = rot_q;
      grant_idx_d  = grant_idx_q;
      grant_none_d = grant_none_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               rot_d   = mask_rot;
               state_d = StScan;
            end
         end
         StScan: begin
            if (rot_q == '0) begin
               grant_none_d = 1'b1;
               grant_idx_d  = '0;
            end else begin
               grant_none_d = 1'b0;
               grant_idx_d  = idx_wrapped;
            end
            state_d = StHold;
         end
         StHold: begin
            if (grant_ready) begin
               state_d = StIdle;
               if (!grant_none_q) begin
                  ptr_d = (grant_idx_q == LastIdx) ? '0 : grant_idx_q + W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         rot_q        <= '0;
         grant_idx_q  <= '0;
         grant_none_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         rot_q        <= rot_d;
         grant_idx_q  <= grant_idx_d;
         grant_none_q <= grant_none_d;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign grant_valid = (state_q == StHold);
   assign grant_idx   = grant_idx_q;
   assign grant_none  = grant_none_q;

endmodule

// File: tb/tb_rr_var_picker.sv
// Directed bench for rr_var_picker: an N=8 instance for the main scenarios
// and an N=6 instance for the non-power-of-two case plus random picks
// checked against a simple forward-search reference.
module tb_rr_var_picker;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // N = 8 instance
   logic       req_valid8 = 1'b0;
   logic       req_ready8;
   logic [7:0] mask8 = '0;
   logic       grant_valid8;
   logic       grant_ready8 = 1'b0;
   logic [2:0] grant_idx8;
   logic       grant_none8;

   rr_var_picker #(.N(8)) dut8 (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid8),
      .req_ready   (req_ready8),
      .mask        (mask8),
      .grant_valid (grant_valid8),
      .grant_ready (grant_ready8),
      .grant_idx   (grant_idx8),
      .grant_none  (grant_none8)
   );

   // N = 6 instance
   logic       req_valid6 = 1'b0;
   logic       req_ready6;
   logic [5:0] mask6 = '0;
   logic       grant_valid6;
   logic       grant_ready6 = 1'b0;
   logic [2:0] grant_idx6;
   logic       grant_none6;

   rr_var_picker #(.N(6)) dut6 (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid6),
      .req_ready   (req_ready6),
      .mask        (mask6),
      .grant_valid (grant_valid6),
      .grant_ready (grant_ready6),
      .grant_idx   (grant_idx6),
      .grant_none  (grant_none6)
   );

   // One full pick on the N=8 instance with latency and handshake checks.
   task automatic pick8(input logic [7:0] m, input logic [2:0] ei, input logic en,
                        input string nm);
      int cyc = 0;
      while (req_ready8 !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (req_ready8 !== 1'b1) begin
         failures++;
         $display("FAIL %s idle-wait req_ready got=%b exp=1", nm, req_ready8);
      end
      req_valid8 = 1'b1;
      mask8      = m;
      @(posedge clk); #1;
      req_valid8 = 1'b0;
      mask8      = ~m;  // must not affect the pick already sampled
      checks++;
      if (grant_valid8 !== 1'b0 || req_ready8 !== 1'b0) begin
         failures++;
         $display("FAIL %s scan gv/rr got=%b%b exp=00", nm, grant_valid8, req_ready8);
      end
      @(posedge clk); #1;
      checks++;
      if (grant_valid8 !== 1'b1) begin
         failures++;
         $display("FAIL %s latency grant_valid got=%b exp=1", nm, grant_valid8);
      end
      checks++;
      if (grant_idx8 !== ei) begin
         failures++;
         $display("FAIL %s grant_idx got=%0d exp=%0d", nm, grant_idx8, ei);
      end
      checks++;
      if (grant_none8 !== en) begin
         failures++;
         $display("FAIL %s grant_none got=%b exp=%b", nm, grant_none8, en);
      end
      grant_ready8 = 1'b1;
      @(posedge clk); #1;
      grant_ready8 = 1'b0;
      checks++;
      if (grant_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
         failures++;
         $display("FAIL %s release gv/rr got=%b%b exp=01", nm, grant_valid8, req_ready8);
      end
   endtask

   // One full pick on the N=6 instance.
   task automatic pick6(input logic [5:0] m, input logic [2:0] ei, input logic en,
                        input string nm);
      int cyc = 0;
      while (req_ready6 !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (req_ready6 !== 1'b1) begin
         failures++;
         $display("FAIL %s idle-wait req_ready got=%b exp=1", nm, req_ready6);
      end
      req_valid6 = 1'b1;
      mask6      = m;
      @(posedge clk); #1;
      req_valid6 = 1'b0;
      mask6      = ~m;
      @(posedge clk); #1;
      checks++;
      if (grant_valid6 !== 1'b1 || grant_idx6 !== ei || grant_none6 !== en) begin
         failures++;
         $display("FAIL %s mask=%b gv/idx/none got=%b/%0d/%b exp=1/%0d/%b", nm, m,
                  grant_valid6, grant_idx6, grant_none6, ei, en);
      end
      grant_ready6 = 1'b1;
      @(posedge clk); #1;
      grant_ready6 = 1'b0;
      checks++;
      if (grant_valid6 !== 1'b0 || req_ready6 !== 1'b1) begin
         failures++;
         $display("FAIL %s release gv/rr got=%b%b exp=01", nm, grant_valid6, req_ready6);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready8 !== 1'b1 || grant_valid8 !== 1'b0 || grant_idx8 !== 3'd0 ||
          grant_none8 !== 1'b0) begin
         failures++;
         $display("FAIL reset rr/gv/idx/none got=%b/%b/%0d/%b exp=1/0/0/0",
                  req_ready8, grant_valid8, grant_idx8, grant_none8);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      pick8(8'b0010_0100, 3'd2, 1'b0, "rr_first");
      pick8(8'b0010_0100, 3'd5, 1'b0, "rr_second");
      pick8(8'b0010_0100, 3'd2, 1'b0, "rr_wrap");
   endtask

   task automatic test_empty();
      // ptr = 3 here
      pick8(8'h00, 3'd0, 1'b1, "empty_none");
      pick8(8'h08, 3'd3, 1'b0, "empty_ptr_kept");
   endtask

   task automatic test_wrap();
      // ptr = 4 here
      pick8(8'h80, 3'd7, 1'b0, "wrap_top");
      pick8(8'hFF, 3'd0, 1'b0, "wrap_ptr_zero");
   endtask

   task automatic test_backpressure();
      // ptr = 1; only bit 0 set, so the search wraps all the way round
      req_valid8 = 1'b1;
      mask8      = 8'h01;
      @(posedge clk); #1;
      req_valid8 = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         mask8      = (i % 2 == 0) ? 8'hFF : 8'h40;
         req_valid8 = 1'b1;  // offered while busy: must be ignored
         checks++;
         if (grant_valid8 !== 1'b1 || grant_idx8 !== 3'd0 || grant_none8 !== 1'b0 ||
             req_ready8 !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d gv/idx/none/rr got=%b/%0d/%b/%b exp=1/0/0/0",
                     i, grant_valid8, grant_idx8, grant_none8, req_ready8);
         end
         @(posedge clk); #1;
      end
      req_valid8   = 1'b0;
      grant_ready8 = 1'b1;
      @(posedge clk); #1;
      grant_ready8 = 1'b0;
      checks++;
      if (grant_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
         failures++;
         $display("FAIL bp_release gv/rr got=%b%b exp=01", grant_valid8, req_ready8);
      end
      // ptr = 1 after granting 0
      pick8(8'h03, 3'd1, 1'b0, "bp_after");
   endtask

   task automatic test_reset_mid_scan();
      req_valid8 = 1'b1;
      mask8      = 8'h10;
      @(posedge clk); #1;
      req_valid8 = 1'b0;
      reset      = 1'b1;  // now in SCAN
      #1;
      checks++;
      if (req_ready8 !== 1'b1 || grant_valid8 !== 1'b0 || grant_idx8 !== 3'd0 ||
          grant_none8 !== 1'b0) begin
         failures++;
         $display("FAIL rst_async rr/gv/idx/none got=%b/%b/%0d/%b exp=1/0/0/0",
                  req_ready8, grant_valid8, grant_idx8, grant_none8);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (grant_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
            failures++;
            $display("FAIL rst_no_grant cyc=%0d gv/rr got=%b%b exp=01",
                     i, grant_valid8, req_ready8);
         end
      end
      pick8(8'h11, 3'd0, 1'b0, "rst_ptr_zero");
   endtask

   task automatic test_n6();
      int         ptr_m;
      logic [5:0] m;
      logic [2:0] ei;
      logic       en;
      int         idx;
      // instance was reset with everything else; ptr = 0
      pick6(6'b010000, 3'd4, 1'b0, "n6_to_5");
      pick6(6'b000001, 3'd0, 1'b0, "n6_wrap");
      ptr_m = 1;
      for (int k = 0; k < 1000; k++) begin
         m  = 6'($urandom_range(0, 63));
         ei = 3'd0;
         en = 1'b1;
         for (int s = 0; s < 6; s++) begin
            idx = (ptr_m + s) % 6;
            if (en && m[idx]) begin
               ei = 3'(idx);
               en = 1'b0;
            end
         end
         pick6(m, ei, en, "n6_random");
         if (!en) ptr_m = (int'(ei) + 1) % 6;
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_empty();
      test_wrap();
      test_backpressure();
      test_reset_mid_scan();
      test_n6();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
